// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state codes and the
// RISC-V load/store funct3 encodings.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Load encodings; stores reuse the low two bits (SB/SH/SW/SD).
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_BAD = 3'b111;

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational access decode: legality/misalignment check, byte-lane mask,
// store-data lane shift and load-data extract with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB   = XLEN / 8,
    localparam int OFFW = $clog2(NB)
) (
    input  logic            i_store,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic            o_trap,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [NB-1:0]   o_mask,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_rdata
);

    logic [OFFW-1:0] w_off;
    logic [1:0]      w_size;
    logic [3:0]      w_nbytes;
    logic [OFFW-1:0] w_low;
    logic            w_illegal;
    logic            w_misaligned;
    logic [NB-1:0]   w_base;
    logic [XLEN-1:0] w_shifted;
    logic            w_sign;

    assign w_off    = i_addr[OFFW-1:0];
    assign w_size   = i_funct3[1:0];
    assign w_nbytes = size_bytes(w_size);
    assign w_low    = OFFW'(w_nbytes - 4'd1);

    // Doubleword and LWU only exist on a 64-bit datapath.
    assign w_illegal = ((XLEN == 32) && (i_funct3 == F3_LD || i_funct3 == F3_LWU))
                     || (!i_store && i_funct3 == F3_BAD)
                     || (i_store && i_funct3[2]);
    assign w_misaligned = |(w_off & w_low);
    assign o_trap       = w_illegal | w_misaligned;

    assign o_mem_addr = {i_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign o_mask     = w_base << w_off;
    assign o_wdata    = i_wdata << {w_off, 3'b000};
    assign w_shifted  = i_rdata >> {w_off, 3'b000};

    always_comb begin
        w_sign = 1'b0;
        case (w_size)
            2'd0:    w_sign = w_shifted[7];
            2'd1:    w_sign = w_shifted[15];
            2'd2:    w_sign = w_shifted[31];
            default: w_sign = w_shifted[XLEN-1];
        endcase
    end

    // Lanes below the access size carry data; the rest carry the extension.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign w_base[gi] = (4'(gi) < w_nbytes);
        assign o_rdata[8*gi +: 8] = w_base[gi] ? w_shifted[8*gi +: 8]
                                               : {8{w_sign & ~i_funct3[2]}};
    end

endmodule

// File: rtl/lsu.sv
// Multi-cycle load/store unit: accepts one access from the pipeline, runs a
// valid/ready memory transaction and returns an extended load result or trap.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB  = XLEN / 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_store,
    input  logic [2:0]      i_req_funct3,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [XLEN-1:0] i_req_wdata,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [XLEN-1:0] o_rsp_rdata,
    output logic            o_rsp_trap,
    output logic            o_mem_valid,
    input  logic            i_mem_ready,
    output logic [XLEN-1:0] o_mem_addr,
    output logic            o_mem_wen,
    output logic [NB-1:0]   o_mem_mask,
    output logic [XLEN-1:0] o_mem_wdata,
    input  logic            i_mem_rvalid,
    input  logic [XLEN-1:0] i_mem_rdata
);

    lsu_state_e      r_state;
    lsu_state_e      w_state_next;
    logic            r_store;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_addr;
    logic            r_mem_valid;
    logic [XLEN-1:0] r_mem_addr;
    logic [NB-1:0]   r_mem_mask;
    logic [XLEN-1:0] r_mem_wdata;
    logic            r_rsp_valid;
    logic            r_rsp_trap;
    logic [XLEN-1:0] r_rsp_rdata;

    logic            w_idle;
    logic            w_sel_store;
    logic [2:0]      w_sel_funct3;
    logic [XLEN-1:0] w_sel_addr;
    logic            w_trap;
    logic [XLEN-1:0] w_al_addr;
    logic [NB-1:0]   w_al_mask;
    logic [XLEN-1:0] w_al_wdata;
    logic [XLEN-1:0] w_al_rdata;
    logic            w_accept;
    logic            w_mem_done;
    logic            w_load_done;
    logic            w_rsp_done;

    // In IDLE the decoder checks the incoming request; afterwards it works on
    // the latched one so the load offset/size are known when data returns.
    assign w_idle       = (r_state == ST_IDLE);
    assign w_sel_store  = w_idle ? i_req_store  : r_store;
    assign w_sel_funct3 = w_idle ? i_req_funct3 : r_funct3;
    assign w_sel_addr   = w_idle ? i_req_addr   : r_addr;

    lsu_align #(.XLEN(XLEN)) u_align (
        .i_store    (w_sel_store),
        .i_funct3   (w_sel_funct3),
        .i_addr     (w_sel_addr),
        .i_wdata    (i_req_wdata),
        .i_rdata    (i_mem_rdata),
        .o_trap     (w_trap),
        .o_mem_addr (w_al_addr),
        .o_mask     (w_al_mask),
        .o_wdata    (w_al_wdata),
        .o_rdata    (w_al_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_mem_done   = 1'b0;
        w_load_done  = 1'b0;
        w_rsp_done   = 1'b0;
        case (r_state)
            ST_IDLE: if (i_req_valid) begin
                w_accept     = 1'b1;
                w_state_next = w_trap ? ST_RESP : ST_REQ;
            end
            ST_REQ: if (i_mem_ready) begin
                w_mem_done   = 1'b1;
                w_state_next = r_store ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: if (i_mem_rvalid) begin
                w_load_done  = 1'b1;
                w_state_next = ST_RESP;
            end
            ST_RESP: if (i_rsp_ready) begin
                w_rsp_done   = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_store     <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr      <= '0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_mask  <= '0;
            r_mem_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_trap  <= 1'b0;
            r_rsp_rdata <= '0;
        end else if (w_accept) begin
            r_store     <= i_req_store;
            r_funct3    <= i_req_funct3;
            r_addr      <= i_req_addr;
            r_mem_valid <= ~w_trap;
            r_mem_addr  <= w_al_addr;
            r_mem_mask  <= w_al_mask;
            r_mem_wdata <= w_al_wdata;
            r_rsp_valid <= w_trap;
            r_rsp_trap  <= w_trap;
            r_rsp_rdata <= '0;
        end else if (w_mem_done) begin
            r_mem_valid <= 1'b0;
            r_rsp_valid <= r_store;
        end else if (w_load_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_al_rdata;
        end else if (w_rsp_done) begin
            r_rsp_valid <= 1'b0;
            r_rsp_trap  <= 1'b0;
            r_rsp_rdata <= '0;
        end
    end

    assign o_req_ready = w_idle;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_trap  = r_rsp_trap;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_mem_valid = r_mem_valid;
    assign o_mem_wen   = r_mem_valid & r_store;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_mask  = r_mem_mask;
    assign o_mem_wdata = r_mem_wdata;

endmodule
